// File: rtl/latch_exerciser_pkg.sv
// latch_exerciser_pkg: FSM state type, fixed (en,d) pattern table and LFSR constants shared by latch_exerciser
package latch_exerciser_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  localparam logic [0:15][1:0] PATTERN = {
    2'b10, 2'b00, 2'b11, 2'b01, 2'b10, 2'b01, 2'b11, 2'b01,
    2'b10, 2'b10, 2'b01, 2'b10, 2'b00, 2'b11, 2'b01, 2'b11
  };
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
endpackage

// File: rtl/latch_exerciser_pattern.sv
// latch_exerciser_pattern: (en,d) source, fixed ROM or 8-bit LFSR when LATCH_EXERCISER_LFSR_EN is defined; ports clk, rst_n, load (restart), step (next phase) -> en, d
module latch_exerciser_pattern
  import latch_exerciser_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic step,
  output logic en,
  output logic d
);
`ifdef LATCH_EXERCISER_LFSR_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr <= LFSR_SEED;
    else lfsr <= load ? LFSR_SEED : step ? {lfsr[6:0], ^(lfsr & LFSR_TAPS)} : lfsr;
  assign en = lfsr[0];
  assign d  = lfsr[1];
`else
  logic [3:0] idx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idx <= '0;
    else idx <= load ? '0 : step ? idx + 4'd1 : idx;
  assign en = PATTERN[idx][1];
  assign d  = PATTERN[idx][0];
`endif
endmodule

// File: rtl/latch_exerciser.sv
// latch_exerciser: drives a D latch through (en,d) phases and counts lat_q mismatches; ports clk, rst_n, start -> busy, done, pass, err_cnt, phase_idx, lat_en, lat_d; lat_q in; LATCH_EXERCISER_LFSR_EN selects the LFSR pattern
module latch_exerciser
  import latch_exerciser_pkg::*;
#(
  parameter int PHASE_CYCLES = 4,
  parameter int SETTLE       = 2,
  parameter int NUM_PHASES   = 16,
  parameter int ERR_W        = 8,
  localparam int PW = NUM_PHASES > 1 ? $clog2(NUM_PHASES) : 1,
  localparam int CW = $clog2(PHASE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [PW-1:0]    phase_idx,
  output logic             lat_en,
  output logic             lat_d,
  input  logic             lat_q
);
  state_t state, next_state;
  logic [CW-1:0] cnt;
  logic exp_q, exp_valid, pat_en, pat_d;
  logic go, last_cyc, last_phase, new_phase, mismatch;
  assign go         = state == IDLE && start;
  assign last_cyc   = state == RUN && cnt == CW'(PHASE_CYCLES - 1);
  assign last_phase = phase_idx == PW'(NUM_PHASES - 1);
  assign new_phase  = go || (last_cyc && !last_phase);
  assign mismatch   = state == RUN && cnt == CW'(SETTLE) && exp_valid && lat_q != exp_q;
  // step one cycle early so the next phase's values are ready when the phase register loads
  latch_exerciser_pattern u_pattern (
    .clk  (clk),
    .rst_n(rst_n),
    .load (state != RUN),
    .step (state == RUN && cnt == CW'(PHASE_CYCLES - 2)),
    .en   (pat_en),
    .d    (pat_d)
  );
  always_comb begin
    next_state = state;
    next_state = go ? RUN : (last_cyc && last_phase) ? FIN : state == FIN ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next_state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt       <= '0;
      phase_idx <= '0;
      exp_q     <= 1'b0;
      exp_valid <= 1'b0;
      err_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      lat_en    <= 1'b0;
      lat_d     <= 1'b0;
    end else begin
      cnt       <= (go || last_cyc) ? '0 : state == RUN ? cnt + CW'(1) : cnt;
      phase_idx <= go ? '0 : new_phase ? phase_idx + PW'(1) : phase_idx;
      exp_q     <= (new_phase && pat_en) ? pat_d : go ? 1'b0 : exp_q;
      exp_valid <= (new_phase && pat_en) || (!go && exp_valid);
      err_cnt   <= go ? '0 : (mismatch && !(&err_cnt)) ? err_cnt + ERR_W'(1) : err_cnt;
      busy      <= next_state == RUN;
      done      <= state == FIN;
      pass      <= go ? 1'b0 : state == FIN ? err_cnt == '0 : pass;
      lat_en    <= next_state != RUN ? 1'b0 : new_phase ? pat_en : lat_en;
      lat_d     <= next_state != RUN ? 1'b0 : new_phase ? pat_d : lat_d;
    end
endmodule

// File: tb/tb_latch_exerciser.sv
// tb_latch_exerciser: directed runs with ideal, stuck-at-0 and transparent latch models plus a saturating ERR_W=2 instance
module tb_latch_exerciser;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  always #5 clk = ~clk;
  logic busy, done, pass, lat_en, lat_d, lat_q;
  logic [7:0] err_cnt;
  logic [3:0] phase_idx;
  logic busy2, done2, pass2, lat_en2, lat_d2;
  logic [1:0] err2;
  logic [3:0] phase_idx2;
  logic [1:0] mode = 2'd0;
  logic ideal_q = 1'b0;
  always @(negedge clk) if (lat_en) ideal_q <= lat_d;
  assign lat_q = mode == 2'd1 ? 1'b0 : mode == 2'd2 ? lat_d : ideal_q;
  latch_exerciser dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .phase_idx(phase_idx), .lat_en(lat_en), .lat_d(lat_d), .lat_q(lat_q)
  );
  latch_exerciser #(.ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .phase_idx(phase_idx2), .lat_en(lat_en2), .lat_d(lat_d2), .lat_q(1'b0)
  );
  int checks = 0, errors = 0, n = 0, seen = 0;
  logic [3:0] pidx9;
  logic d9;
  logic [1:0] sat33;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int repulse_at, input int hold_from, output int cnt);
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    chk("busy_at_start", busy, 1);
    chk("phase0_en", lat_en, 1);
    while (!done && cnt < 200) begin
      tick();
      cnt++;
      start = (cnt == repulse_at) || (cnt >= hold_from);
      if (cnt == 9) begin
        pidx9 = phase_idx;
        d9 = lat_d;
      end
      if (cnt == 33) sat33 = err2;
    end
  endtask
  initial begin
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_phase", phase_idx, 0);
    chk("rst_lat_en", lat_en, 0);
    chk("rst_lat_d", lat_d, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_busy", busy, 0);
    mode = 2'd0;
    run(-1, 1000, n);
    chk("ideal_done_cycle", n, 65);
    chk("ideal_err", err_cnt, 0);
    chk("ideal_pass", pass, 1);
    chk("ideal_busy_at_done", busy, 0);
    chk("phase2_idx", pidx9, 2);
    chk("phase2_d", d9, 1);
    repeat (5) tick();
    chk("pass_held", pass, 1);
    chk("done_one_cycle", done, 0);
    mode = 2'd1;
    run(-1, 1000, n);
    chk("stuck_done_cycle", n, 65);
    chk("stuck_err", err_cnt, 7);
    chk("stuck_pass", pass, 0);
    chk("sat_mid_run", sat33, 3);
    chk("sat_end", err2, 3);
    repeat (2) tick();
    mode = 2'd2;
    run(-1, 1000, n);
    chk("transp_done_cycle", n, 65);
    chk("transp_err", err_cnt, 2);
    chk("transp_pass", pass, 0);
    repeat (2) tick();
    mode = 2'd0;
    run(20, 1000, n);
    chk("repulse_done_cycle", n, 65);
    chk("repulse_err", err_cnt, 0);
    repeat (2) tick();
    mode = 2'd1;
    run(-1, 60, n);
    chk("hold_done_cycle", n, 65);
    chk("hold_err", err_cnt, 7);
    tick();
    start = 1'b0;
    chk("restart_busy", busy, 1);
    chk("restart_err", err_cnt, 0);
    chk("restart_pass", pass, 0);
    repeat (12) tick();
    chk("mid_run_err", err_cnt, 1);
    rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_err", err_cnt, 0);
    chk("async_phase", phase_idx, 0);
    chk("async_lat_d", lat_d, 0);
    chk("async_done", done, 0);
    tick();
    rst_n = 1'b1;
    repeat (80) begin
      tick();
      if (done || busy) seen++;
    end
    chk("idle_after_reset", seen, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/latch_exerciser.md
# latch_exerciser

Stimulus-and-check engine for a level-sensitive D latch under test. It drives the latch's enable and data inputs through a sequence of phases, samples the latch output back, and compares it against an internal reference model. It sits beside the latch cell in the assignment top level and replaces hand-written testbench stimulus with a self-checking, synthesizable driver that reports an error count.

## Interface
- PHASE_CYCLES, 4: clock cycles each (EN, D) phase is held; ≥ 2.
- SETTLE, 2: cycle offset within a phase at which LAT_Q is sampled; 1 ≤ SETTLE < PHASE_CYCLES.
- NUM_PHASES, 16: phases per run; ≥ 1.
- ERR_W, 8: ERR_CNT width.

Ports:
- CLK  in  1  single clock; all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  run request, sampled only in IDLE.
- BUSY  out  1  high while a run is in progress.
- DONE  out  1  one-cycle pulse at end of run.
- PASS  out  1  valid from DONE onward: ERR_CNT == 0; held until next START.
- ERR_CNT  out  ERR_W  mismatch count, saturating.
- PHASE_IDX  out  clog2(NUM_PHASES)  current phase number.
- LAT_EN  out  1  drives latch enable (the latch's CLK pin).
- LAT_D  out  1  drives latch D.
- LAT_Q  in  1  latch Q, sampled directly (no synchronizer).

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE: LAT_EN=0, LAT_D=0, BUSY=0. START=1 → RUN. On entry, ERR_CNT, PASS, PHASE_IDX, the cycle counter, and the reference model are cleared. The pattern source is reset to its start.
- RUN: the phase's (EN, D) are registered onto LAT_EN/LAT_D for PHASE_CYCLES cycles.
- The cycle counter runs 0..PHASE_CYCLES-1.
- At count == SETTLE: if exp_valid and LAT_Q ≠ exp_q, ERR_CNT increments, saturating at all-ones.
- At count == PHASE_CYCLES-1: advance the phase. After phase NUM_PHASES-1 → FIN.
- Reference model:
  - In a phase with EN=1: exp_q ← D and exp_valid ← 1, updated at phase start, before that phase's compare.
  - In a phase with EN=0: exp_q is held.
  - Compares are skipped while exp_valid=0, so a leading EN=0 phase is unchecked.
- FIN: one cycle. DONE=1, BUSY=0, PASS set, LAT_EN=0 → IDLE.
- START in RUN or FIN is ignored.
- Fixed pattern (EN,D), phase i uses entry i mod 16: (1,0)(0,0)(1,1)(0,1)(1,0)(0,1)(1,1)(0,1)(1,0)(1,0)(0,1)(1,0)(0,0)(1,1)(0,1)(1,1).

## Timing
- Reset values: BUSY=0, DONE=0, PASS=0, ERR_CNT=0, PHASE_IDX=0, LAT_EN=0, LAT_D=0, state IDLE.
- Reset takes effect immediately, including mid-run; no DONE pulse is issued for an aborted run.
- START sampled at edge k:
  - BUSY=1 and phase 0 on LAT_EN/LAT_D after edge k.
  - Phase p occupies cycles k+1+p·PHASE_CYCLES through k+(p+1)·PHASE_CYCLES.
  - DONE=1 for the cycle after edge k+1+NUM_PHASES·PHASE_CYCLES (defaults: 65 cycles after the START edge).
- All outputs are registered. LAT_Q must settle within SETTLE cycles of the phase change.

## Configuration
- LATCH_EXERCISER_LFSR_EN defined: (EN, D) come from an 8-bit Fibonacci LFSR.
  - Polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5, reloaded on START.
  - Stepped once per phase; EN=bit0, D=bit1.
- Not defined: the fixed 16-entry pattern above is used.
- FSM, checking and timing are identical in both builds.

## Structure
- Package latch_exerciser_pkg: state enum (IDLE/RUN/FIN), 16-entry fixed pattern constant, LFSR seed and tap constants.
- Sub-module latch_exerciser_pattern: pattern source (ROM or LFSR per macro). Inputs: CLK, RST_N, load, step. Outputs: en, d.
- The FSM, counters and reference model live in the top level.

## Test plan
- Reset: assert RST_N=0 mid-run → all outputs at reset values at once; release, hold START=0 → stays IDLE, no DONE.
- Ideal latch model on LAT_Q, defaults, fixed pattern, START pulse → DONE exactly 65 cycles after the START edge, ERR_CNT=0, PASS=1.
- LAT_Q stuck at 0, fixed pattern → ERR_CNT=7 (phases 2,3,6,7,13,14,15), PASS=0.
- Always-transparent faulty latch (LAT_Q=LAT_D), fixed pattern → ERR_CNT=2 (phases 5,10).
- ERR_W=2, LAT_Q stuck at 0 → ERR_CNT saturates at 3, no wrap.
- START re-pulsed during RUN → ignored, same DONE cycle. START held high through FIN → new run begins the cycle after DONE, with ERR_CNT cleared.
